pu_tile_scheduler: RTL and testbench
====================================

Name: pu_tile_scheduler

Overview:
- Sequences the combinational processing unit across a full Smith-Waterman score matrix, one NUM_ROWS_PE x NUM_COLS_PE tile at a time, in row-major tile order.
- Issues tile-granular letter-memory reads and selects zero borders on the first tile row and first tile column.
- Strobes capture of border scores and traceback sources, and tracks the global best score and its matrix position.
- Sits between the top-level host/control interface and the processing unit, the border score buffers and the traceback memory.

Parameters:
- NUM_ROWS_PE, 4, PE rows per tile (database letters per tile).
- NUM_COLS_PE, 4, PE columns per tile (query letters per tile).
- SCORE_WIDTH, 8, score width.
- TILE_CNT_WIDTH, 8, width of tile counters and of tile read addresses.
- POS_WIDTH, TILE_CNT_WIDTH+$clog2(max(NUM_ROWS_PE,NUM_COLS_PE)), width of matrix row/column position.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to run an alignment.
- abort  in  1  synchronous abort.
- cfg_row_tiles  in  TILE_CNT_WIDTH  number of database tiles (R).
- cfg_col_tiles  in  TILE_CNT_WIDTH  number of query tiles (C).
- hold  in  1  downstream back-pressure (traceback memory not ready).
- tile_max_score  in  SCORE_WIDTH  maximum score of the current tile, from the PU.
- tile_max_lrow  in  $clog2(NUM_ROWS_PE)  local row of tile_max_score.
- tile_max_lcol  in  $clog2(NUM_COLS_PE)  local column of tile_max_score.
- rd_en  out  1  letter-memory read strobe.
- query_rd_addr  out  TILE_CNT_WIDTH  query tile address (= tile column c).
- db_rd_addr  out  TILE_CNT_WIDTH  database tile address (= tile row r).
- top_zero  out  1  PU top and diagonal borders forced to 0 (r==0).
- left_zero  out  1  PU left and diagonal borders forced to 0 (c==0).
- capture  out  1  write PU outputs to the border buffers and traceback memory this cycle.
- tile_row  out  TILE_CNT_WIDTH  current tile row r.
- tile_col  out  TILE_CNT_WIDTH  current tile column c.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- best_score  out  SCORE_WIDTH  global maximum score.
- best_row  out  POS_WIDTH  matrix row of best_score.
- best_col  out  POS_WIDTH  matrix column of best_score.

Behaviour:
- Reset: every output is 0, the FSM is in IDLE, r=c=0, and the best_* registers are 0.
- FSM states are IDLE, FETCH, COMPUTE, DONE.
- IDLE:
  - On start, latch cfg_row_tiles and cfg_col_tiles, clear r, c and best_*.
  - If either count is 0, go to DONE; otherwise go to FETCH.
  - start is ignored in every other state.
- FETCH (one cycle):
  - rd_en=1; query_rd_addr=c, db_rd_addr=r.
  - Next state is COMPUTE, unconditionally.
  - Letter memory has a 1-cycle read latency, so letters are valid in COMPUTE.
- COMPUTE:
  - The PU evaluates combinationally; top_zero and left_zero are valid in FETCH and COMPUTE.
  - If hold=1: capture=0, stay in COMPUTE, and the letters stay held by the memory output register.
  - If hold=0: capture=1 for exactly that cycle, and the max tracker updates.
  - After the capture cycle, advance: if c<C-1 then c++; else c=0 and r++.
  - If the tile just captured was (R-1,C-1), go to DONE; otherwise go to FETCH.
- DONE: done=1 for one cycle, then IDLE. best_* are held until the next accepted start.
- Timing with hold=0: start is accepted at cycle 0, the first FETCH is at cycle 1, the last capture is at cycle 2·R·C, and done is at cycle 2·R·C+1.
- Max tracker, on capture only:
  - Candidate row = r·NUM_ROWS_PE+tile_max_lrow; candidate column = c·NUM_COLS_PE+tile_max_lcol (unsigned, POS_WIDTH).
  - Update only if tile_max_score > best_score (strictly greater), so ties keep the earliest tile in row-major order.
- abort:
  - In any non-IDLE state, go to IDLE next cycle with no done and no capture in that cycle.
  - best_* retain partial results.
  - abort has priority over hold and over advancing.
- Simultaneous start and abort in IDLE: start wins, because abort has no effect in IDLE.
- Reset asserted mid-run: immediate return to reset values; the next run requires a new start.

Test Plan:
- R=2, C=3, hold=0, tile_max_score=0 throughout: expect 6 captures at cycles 2,4,…,12, tile (r,c) order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2), done at cycle 13, busy high on cycles 1–13. top_zero is high only on tiles with r=0; left_zero is high only on tiles with c=0.
- R=1, C=1, hold high for 3 cycles during COMPUTE: capture is delayed to cycle 5, done at cycle 6, rd_en is high only at cycle 1.
- Max tracking, R=2, C=2, NUM_ROWS_PE=NUM_COLS_PE=4, tile_max_score sequence 5, 9, 9, 3 with (lrow,lcol)=(1,2) each: expect best_score=9, best_row=1, best_col=6 (tile (0,1) wins the tie against tile (1,0)).
- cfg_row_tiles=0, C=4, start: expect done at cycle 1, no rd_en, no capture.
- abort asserted in the third COMPUTE cycle of an R=2, C=2 run: no further capture, busy=0 next cycle, done never asserted, then a new start runs normally from (0,0).
- rst_n pulsed low mid-run: all outputs read 0 immediately (asynchronously); start pulses while busy are ignored (no restart, tile order unchanged).

Source files
------------

// File: rtl/pu_tile_scheduler_if.sv
// Signal bundle between the tile scheduler and its neighbours: host control,
// PU tile-max results, letter-memory reads, border-select and capture strobes.
interface pu_tile_scheduler_if #(
   parameter int NUM_ROWS_PE    = 4,
   parameter int NUM_COLS_PE    = 4,
   parameter int SCORE_WIDTH    = 8,
   parameter int TILE_CNT_WIDTH = 8,
   parameter int POS_WIDTH      = TILE_CNT_WIDTH +
                                  $clog2((NUM_ROWS_PE > NUM_COLS_PE) ? NUM_ROWS_PE : NUM_COLS_PE)
);
   localparam int LROW_W = $clog2(NUM_ROWS_PE);
   localparam int LCOL_W = $clog2(NUM_COLS_PE);

   logic                      start;
   logic                      abort;
   logic [TILE_CNT_WIDTH-1:0] cfg_row_tiles;
   logic [TILE_CNT_WIDTH-1:0] cfg_col_tiles;
   logic                      hold;
   logic [SCORE_WIDTH-1:0]    tile_max_score;
   logic [LROW_W-1:0]         tile_max_lrow;
   logic [LCOL_W-1:0]         tile_max_lcol;

   logic                      rd_en;
   logic [TILE_CNT_WIDTH-1:0] query_rd_addr;
   logic [TILE_CNT_WIDTH-1:0] db_rd_addr;
   logic                      top_zero;
   logic                      left_zero;
   logic                      capture;
   logic [TILE_CNT_WIDTH-1:0] tile_row;
   logic [TILE_CNT_WIDTH-1:0] tile_col;
   logic                      busy;
   logic                      done;
   logic [SCORE_WIDTH-1:0]    best_score;
   logic [POS_WIDTH-1:0]      best_row;
   logic [POS_WIDTH-1:0]      best_col;

   // The scheduler side.
   modport master (
      input  start, abort, cfg_row_tiles, cfg_col_tiles, hold,
             tile_max_score, tile_max_lrow, tile_max_lcol,
      output rd_en, query_rd_addr, db_rd_addr, top_zero, left_zero, capture,
             tile_row, tile_col, busy, done, best_score, best_row, best_col
   );

   // The host / PU / memory side.
   modport slave (
      output start, abort, cfg_row_tiles, cfg_col_tiles, hold,
             tile_max_score, tile_max_lrow, tile_max_lcol,
      input  rd_en, query_rd_addr, db_rd_addr, top_zero, left_zero, capture,
             tile_row, tile_col, busy, done, best_score, best_row, best_col
   );
endinterface

// File: rtl/pu_tile_scheduler.sv
// Walks the Smith-Waterman matrix tile by tile in row-major order, strobing
// letter fetches and captures, and tracks the global best score and position.
module pu_tile_scheduler #(
   parameter int NUM_ROWS_PE    = 4,
   parameter int NUM_COLS_PE    = 4,
   parameter int SCORE_WIDTH    = 8,
   parameter int TILE_CNT_WIDTH = 8,
   parameter int POS_WIDTH      = TILE_CNT_WIDTH +
                                  $clog2((NUM_ROWS_PE > NUM_COLS_PE) ? NUM_ROWS_PE : NUM_COLS_PE)
) (
   input logic                clk,
   input logic                rst_n,
   pu_tile_scheduler_if.master bus
);
   typedef enum logic [1:0] {IDLE, FETCH, COMPUTE, DONE} state_t;

   state_t                    state_q, state_d;
   logic [TILE_CNT_WIDTH-1:0] r_q, r_d;
   logic [TILE_CNT_WIDTH-1:0] c_q, c_d;
   logic [TILE_CNT_WIDTH-1:0] rows_q, rows_d;
   logic [TILE_CNT_WIDTH-1:0] cols_q, cols_d;
   logic [SCORE_WIDTH-1:0]    best_score_q, best_score_d;
   logic [POS_WIDTH-1:0]      best_row_q, best_row_d;
   logic [POS_WIDTH-1:0]      best_col_q, best_col_d;

   logic [POS_WIDTH-1:0]      cand_row;
   logic [POS_WIDTH-1:0]      cand_col;
   logic                      last_col;
   logic                      last_tile;
   logic                      cap;

   always_comb begin
      cand_row  = POS_WIDTH'(r_q) * POS_WIDTH'(NUM_ROWS_PE) + POS_WIDTH'(bus.tile_max_lrow);
      cand_col  = POS_WIDTH'(c_q) * POS_WIDTH'(NUM_COLS_PE) + POS_WIDTH'(bus.tile_max_lcol);
      last_col  = (c_q == cols_q - TILE_CNT_WIDTH'(1));
      last_tile = last_col && (r_q == rows_q - TILE_CNT_WIDTH'(1));
   end

   always_comb begin
      state_d      = state_q;
      r_d          = r_q;
      c_d          = c_q;
      rows_d       = rows_q;
      cols_d       = cols_q;
      best_score_d = best_score_q;
      best_row_d   = best_row_q;
      best_col_d   = best_col_q;
      cap          = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               rows_d       = bus.cfg_row_tiles;
               cols_d       = bus.cfg_col_tiles;
               r_d          = '0;
               c_d          = '0;
               best_score_d = '0;
               best_row_d   = '0;
               best_col_d   = '0;
               if ((bus.cfg_row_tiles == '0) || (bus.cfg_col_tiles == '0))
                  state_d = DONE;
               else
                  state_d = FETCH;
            end
         end
         FETCH: state_d = COMPUTE;
         COMPUTE: begin
            // Letters stay stable in the memory output register while held.
            if (!bus.hold) begin
               cap = 1'b1;
               if (bus.tile_max_score > best_score_q) begin
                  best_score_d = bus.tile_max_score;
                  best_row_d   = cand_row;
                  best_col_d   = cand_col;
               end
               if (last_col) begin
                  c_d = '0;
                  r_d = r_q + TILE_CNT_WIDTH'(1);
               end else begin
                  c_d = c_q + TILE_CNT_WIDTH'(1);
               end
               state_d = last_tile ? DONE : FETCH;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Abort overrides hold and advancing but keeps the partial best result.
      if ((state_q != IDLE) && bus.abort) begin
         state_d      = IDLE;
         cap          = 1'b0;
         r_d          = r_q;
         c_d          = c_q;
         best_score_d = best_score_q;
         best_row_d   = best_row_q;
         best_col_d   = best_col_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         r_q          <= '0;
         c_q          <= '0;
         rows_q       <= '0;
         cols_q       <= '0;
         best_score_q <= '0;
         best_row_q   <= '0;
         best_col_q   <= '0;
      end else begin
         state_q      <= state_d;
         r_q          <= r_d;
         c_q          <= c_d;
         rows_q       <= rows_d;
         cols_q       <= cols_d;
         best_score_q <= best_score_d;
         best_row_q   <= best_row_d;
         best_col_q   <= best_col_d;
      end
   end

   assign bus.rd_en         = (state_q == FETCH);
   assign bus.query_rd_addr = c_q;
   assign bus.db_rd_addr    = r_q;
   assign bus.top_zero      = ((state_q == FETCH) || (state_q == COMPUTE)) && (r_q == '0);
   assign bus.left_zero     = ((state_q == FETCH) || (state_q == COMPUTE)) && (c_q == '0);
   assign bus.capture       = cap;
   assign bus.tile_row      = r_q;
   assign bus.tile_col      = c_q;
   assign bus.busy          = (state_q != IDLE);
   assign bus.done          = (state_q == DONE) && !bus.abort;
   assign bus.best_score    = best_score_q;
   assign bus.best_row      = best_row_q;
   assign bus.best_col      = best_col_q;
endmodule

// File: tb/tb_pu_tile_scheduler.sv
// Self-checking bench for pu_tile_scheduler: table of run scenarios with a
// fetch/capture scoreboard, plus a hand-written asynchronous reset sequence.
`timescale 1ns/1ps
module tb_pu_tile_scheduler;
   localparam int NR = 4;
   localparam int NC = 4;
   localparam int SW = 8;
   localparam int TW = 8;
   localparam int PW = TW + 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   pu_tile_scheduler_if #(.NUM_ROWS_PE(NR), .NUM_COLS_PE(NC), .SCORE_WIDTH(SW),
                          .TILE_CNT_WIDTH(TW), .POS_WIDTH(PW)) bus ();

   pu_tile_scheduler #(.NUM_ROWS_PE(NR), .NUM_COLS_PE(NC), .SCORE_WIDTH(SW),
                       .TILE_CNT_WIDTH(TW), .POS_WIDTH(PW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int             rt, ct;       // R, C
      int             hold_tile;    // tile index whose COMPUTE is held, -1 none
      int             hold_len;
      int             abort_cyc;    // cycle abort is high, -1 none
      int             es1, es2;     // extra start pulses while busy, -1 none
      logic [1:0]     lrow, lcol;
      logic [7:0][7:0] sc;          // sc[k] = tile max of k-th tile, row-major
      int             exp_done;     // done cycle, -1 = never
      logic [SW-1:0]  exp_best;
      int             exp_brow, exp_bcol;
   } tv_t;

   typedef struct {
      int cyc;
      int r;
      int c;
   } ev_t;

   int checks   = 0;
   int failures = 0;
   tv_t tv[8];

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic tv_t mkv(input int rt, input int ct, input int ht, input int hl,
                               input int ab, input int es1, input int es2,
                               input int lr, input int lc,
                               input int s0, input int s1, input int s2, input int s3,
                               input int ed, input int eb, input int er, input int ec);
      tv_t v;
      v.rt = rt; v.ct = ct; v.hold_tile = ht; v.hold_len = hl; v.abort_cyc = ab;
      v.es1 = es1; v.es2 = es2;
      v.lrow = lr[1:0]; v.lcol = lc[1:0];
      v.sc = {32'd0, s3[7:0], s2[7:0], s1[7:0], s0[7:0]};
      v.exp_done = ed; v.exp_best = eb[SW-1:0]; v.exp_brow = er; v.exp_bcol = ec;
      return v;
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, ".rd_en"},     bus.rd_en, 0);
      chk({tag, ".qaddr"},     bus.query_rd_addr, 0);
      chk({tag, ".daddr"},     bus.db_rd_addr, 0);
      chk({tag, ".top_zero"},  bus.top_zero, 0);
      chk({tag, ".left_zero"}, bus.left_zero, 0);
      chk({tag, ".capture"},   bus.capture, 0);
      chk({tag, ".tile_row"},  bus.tile_row, 0);
      chk({tag, ".tile_col"},  bus.tile_col, 0);
      chk({tag, ".busy"},      bus.busy, 0);
      chk({tag, ".done"},      bus.done, 0);
      chk({tag, ".best_score"}, bus.best_score, 0);
      chk({tag, ".best_row"},  bus.best_row, 0);
      chk({tag, ".best_col"},  bus.best_col, 0);
   endtask

   task automatic drive_idle();
      bus.start = 1'b0; bus.abort = 1'b0; bus.hold = 1'b0;
      bus.cfg_row_tiles = '0; bus.cfg_col_tiles = '0;
      bus.tile_max_score = '0; bus.tile_max_lrow = '0; bus.tile_max_lcol = '0;
   endtask

   task automatic run_case(input int id, input tv_t v);
      ev_t fq[$];
      ev_t cq[$];
      ev_t e;
      int  ntiles, last_t, ncap, hk, fk, hs;
      bit  exp_busy;

      ntiles = v.rt * v.ct;
      hs     = 2 * v.hold_tile + 2;
      for (int k = 0; k < ntiles; k++) begin
         hk = (v.hold_tile >= 0 && k >= v.hold_tile) ? v.hold_len : 0;
         fk = (v.hold_tile >= 0 && k >  v.hold_tile) ? v.hold_len : 0;
         if (v.abort_cyc <= 0 || (2*k + 1 + fk) < v.abort_cyc)
            fq.push_back('{2*k + 1 + fk, k / v.ct, k % v.ct});
         if (v.abort_cyc <= 0 || (2*k + 2 + hk) < v.abort_cyc)
            cq.push_back('{2*k + 2 + hk, k / v.ct, k % v.ct});
      end
      last_t = (v.exp_done >= 0) ? v.exp_done + 2 : v.abort_cyc + 3;
      ncap   = 0;

      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.cfg_row_tiles = v.rt[TW-1:0];
      bus.cfg_col_tiles = v.ct[TW-1:0];
      bus.abort = (v.abort_cyc == 0);
      bus.hold  = 1'b0;
      bus.tile_max_score = v.sc[0];
      bus.tile_max_lrow  = v.lrow;
      bus.tile_max_lcol  = v.lcol;

      for (int t = 0; t <= last_t; t++) begin
         @(negedge clk);
         exp_busy = (t >= 1) && ((v.exp_done >= 0) ? (t <= v.exp_done) : (t <= v.abort_cyc));
         chk($sformatf("c%0d.busy@%0d", id, t), bus.busy, exp_busy);
         chk($sformatf("c%0d.done@%0d", id, t), bus.done, (t == v.exp_done));
         if (bus.rd_en) begin
            if (fq.size() == 0) begin
               chk($sformatf("c%0d.extra_rd_en@%0d", id, t), 1, 0);
            end else begin
               e = fq.pop_front();
               chk($sformatf("c%0d.rd_cycle", id), t, e.cyc);
               chk($sformatf("c%0d.db_rd_addr", id), bus.db_rd_addr, e.r);
               chk($sformatf("c%0d.query_rd_addr", id), bus.query_rd_addr, e.c);
               chk($sformatf("c%0d.fetch_top_zero", id), bus.top_zero, (e.r == 0));
               chk($sformatf("c%0d.fetch_left_zero", id), bus.left_zero, (e.c == 0));
            end
         end
         if (bus.capture) begin
            if (cq.size() == 0) begin
               chk($sformatf("c%0d.extra_capture@%0d", id, t), 1, 0);
            end else begin
               e = cq.pop_front();
               $display("case %0d capture t=%0d tile=(%0d,%0d) score=%0d",
                        id, t, bus.tile_row, bus.tile_col, bus.tile_max_score);
               chk($sformatf("c%0d.cap_cycle", id), t, e.cyc);
               chk($sformatf("c%0d.tile_row", id), bus.tile_row, e.r);
               chk($sformatf("c%0d.tile_col", id), bus.tile_col, e.c);
               chk($sformatf("c%0d.cap_top_zero", id), bus.top_zero, (e.r == 0));
               chk($sformatf("c%0d.cap_left_zero", id), bus.left_zero, (e.c == 0));
            end
            ncap++;
         end
         @(posedge clk); #1;
         bus.start = ((t + 1) == v.es1) || ((t + 1) == v.es2);
         bus.abort = ((t + 1) == v.abort_cyc);
         bus.hold  = (v.hold_tile >= 0) && ((t + 1) >= hs) && ((t + 1) < hs + v.hold_len);
         bus.tile_max_score = (ncap < 8) ? v.sc[ncap] : '0;
      end

      chk($sformatf("c%0d.fetches_left", id), fq.size(), 0);
      chk($sformatf("c%0d.captures_left", id), cq.size(), 0);
      chk($sformatf("c%0d.best_score", id), bus.best_score, v.exp_best);
      chk($sformatf("c%0d.best_row", id), bus.best_row, v.exp_brow);
      chk($sformatf("c%0d.best_col", id), bus.best_col, v.exp_bcol);
      $display("case %0d R=%0d C=%0d captures=%0d best=%0d at (%0d,%0d)",
               id, v.rt, v.ct, ncap, bus.best_score, bus.best_row, bus.best_col);
      drive_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //          R  C  ht hl  ab es1 es2 lr lc  s0  s1   s2   s3  done best row col
      tv[0] = mkv(2, 3, -1, 0, -1,  3,  8, 0, 0,  0,  0,   0,   0,  13,   0,  0,  0);
      tv[1] = mkv(1, 1,  0, 3, -1, -1, -1, 3, 1,  5,  0,   0,   0,   6,   5,  3,  1);
      tv[2] = mkv(2, 2, -1, 0, -1, -1, -1, 1, 2,  5,  9,   9,   3,   9,   9,  1,  6);
      tv[3] = mkv(0, 4, -1, 0, -1, -1, -1, 0, 0,  7,  7,   7,   7,   1,   0,  0,  0);
      tv[4] = mkv(2, 2, -1, 0,  6, -1, -1, 2, 3,  7, 12,  20,   1,  -1,  12,  2,  7);
      tv[5] = mkv(2, 2, -1, 0,  0, -1, -1, 1, 0,  3,  3,   8,   8,   9,   8,  5,  0);
      tv[6] = mkv(3, 1,  1, 2, -1, -1, -1, 3, 3,  1,  2, 250,   0,   9, 250, 11,  3);
      tv[7] = mkv(1, 4, -1, 0, -1, -1, -1, 0, 1, 10, 200, 200, 200,   9, 200,  0,  5);

      drive_idle();
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) run_case(i, tv[i]);

      // Asynchronous reset in the middle of an R=2, C=3 run.
      @(posedge clk); #1;
      bus.start = 1'b1; bus.cfg_row_tiles = 8'd2; bus.cfg_col_tiles = 8'd3;
      bus.tile_max_score = 8'd77; bus.tile_max_lrow = 2'd1; bus.tile_max_lcol = 2'd1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      chk("prerst.busy", bus.busy, 1);
      chk("prerst.best_score", bus.best_score, 77);
      chk("prerst.query_rd_addr", bus.query_rd_addr, 2);
      rst_n = 1'b0;
      #1;
      chk_all_zero("midrun_reset");
      #2 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("postrst.busy@%0d", i), bus.busy, 0);
         chk($sformatf("postrst.rd_en@%0d", i), bus.rd_en, 0);
      end
      drive_idle();
      run_case(8, tv[2]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
